// File: rtl/e10_phy_pkg.sv
// rtl/e10_phy_pkg.sv - shared types and constants for the PHY reset sequencer
//
// Holds the counter width, the TX/RX state enumerations and a helper that
// turns a dwell time in cycles into the counter's terminal value.
package e10_phy_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        TX_RST  = 2'd0,
        TX_WAIT = 2'd1,
        TX_DIG  = 2'd2,
        TX_RDY  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_RST  = 2'd0,
        RX_WAIT = 2'd1,
        RX_LTD  = 2'd2,
        RX_RDY  = 2'd3
    } rx_state_t;

    // A state that must dwell n cycles leaves when its counter reads n-1.
    function automatic logic [CNT_W-1:0] cnt_last(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/e10_sync2.sv
// rtl/e10_sync2.sv - two-flop synchronizer for one asynchronous level
//
// Ports:
//   clk      destination clock
//   reset_n  asynchronous active-low reset, clears both flops
//   d        asynchronous input level
//   q        level resynchronized to clk, two cycles of latency
module e10_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/e10_phy_reset_seq.sv
// rtl/e10_phy_reset_seq.sv - TX/RX transceiver reset sequencer
//
// Two independent state machines step a PHY's analog and digital resets.
// TX: analog hold, wait for PLL lock and TX calibration done, digital hold,
// ready. RX: analog hold, wait for CDR lock and RX calibration done, require
// T_LTD continuous locked cycles, ready. Losing lock or calibration sends a
// path back to its WAIT state; a soft reset request sends it back to RST.
//
// Parameters:
//   T_ANALOG   analog reset hold, cycles (1..65535)
//   T_DIGITAL  TX digital reset hold after PLL lock, cycles (1..65535)
//   T_LTD      continuous CDR lock required before RX release, cycles (1..65535)
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   tx_reset_req, rx_reset_req   synchronous soft resets per path
//   pll_locked, tx_cal_busy,
//   rx_cal_busy, rx_is_lockedtodata   asynchronous PHY status
//   tx_analogreset, tx_digitalreset,
//   rx_analogreset, rx_digitalreset   registered resets to the PHY
//   tx_ready, rx_ready           registered path-ready flags
module e10_phy_reset_seq
    import e10_phy_pkg::*;
#(
    parameter int T_ANALOG  = 70,
    parameter int T_DIGITAL = 16,
    parameter int T_LTD     = 4000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tx_reset_req,
    input  logic rx_reset_req,
    input  logic pll_locked,
    input  logic tx_cal_busy,
    input  logic rx_cal_busy,
    input  logic rx_is_lockedtodata,
    output logic tx_analogreset,
    output logic tx_digitalreset,
    output logic rx_analogreset,
    output logic rx_digitalreset,
    output logic tx_ready,
    output logic rx_ready
);

    localparam logic [CNT_W-1:0] TA_LAST = cnt_last(T_ANALOG);
    localparam logic [CNT_W-1:0] TD_LAST = cnt_last(T_DIGITAL);
    localparam logic [CNT_W-1:0] TL_LAST = cnt_last(T_LTD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic pll_s;
    logic tx_cal_s;
    logic rx_cal_s;
    logic ltd_s;

    e10_sync2 u_sync_pll    (.clk(clk), .reset_n(reset_n), .d(pll_locked),         .q(pll_s));
    e10_sync2 u_sync_tx_cal (.clk(clk), .reset_n(reset_n), .d(tx_cal_busy),        .q(tx_cal_s));
    e10_sync2 u_sync_rx_cal (.clk(clk), .reset_n(reset_n), .d(rx_cal_busy),        .q(rx_cal_s));
    e10_sync2 u_sync_ltd    (.clk(clk), .reset_n(reset_n), .d(rx_is_lockedtodata), .q(ltd_s));

    logic tx_ok;
    logic rx_ok;

    assign tx_ok = pll_s && !tx_cal_s;
    assign rx_ok = ltd_s && !rx_cal_s;

    // Goes high on the first edge after reset_n releases. The edge that sets
    // it also (re)enters RST with a cleared counter, so the analog hold is
    // counted from that first edge onward.
    logic seq_run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_run <= 1'b0;
        end else begin
            seq_run <= 1'b1;
        end
    end

    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state        <= TX_RST;
            tx_cnt          <= '0;
            tx_analogreset  <= 1'b1;
            tx_digitalreset <= 1'b1;
            tx_ready        <= 1'b0;
        end else if (tx_reset_req || !seq_run) begin
            // Soft reset outranks any status change seen this cycle.
            tx_state        <= TX_RST;
            tx_cnt          <= '0;
            tx_analogreset  <= 1'b1;
            tx_digitalreset <= 1'b1;
            tx_ready        <= 1'b0;
        end else begin
            case (tx_state)
                TX_RST: begin
                    if (tx_cnt == TA_LAST) begin
                        tx_state       <= TX_WAIT;
                        tx_cnt         <= '0;
                        tx_analogreset <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                TX_WAIT: begin
                    if (tx_ok) begin
                        tx_state <= TX_DIG;
                        tx_cnt   <= '0;
                    end
                end
                TX_DIG: begin
                    if (!tx_ok) begin
                        tx_state <= TX_WAIT;
                        tx_cnt   <= '0;
                    end else if (tx_cnt == TD_LAST) begin
                        tx_state        <= TX_RDY;
                        tx_digitalreset <= 1'b0;
                        tx_ready        <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                TX_RDY: begin
                    if (!tx_ok) begin
                        tx_state        <= TX_WAIT;
                        tx_cnt          <= '0;
                        tx_digitalreset <= 1'b1;
                        tx_ready        <= 1'b0;
                    end
                end
                default: begin
                    tx_state        <= TX_RST;
                    tx_cnt          <= '0;
                    tx_analogreset  <= 1'b1;
                    tx_digitalreset <= 1'b1;
                    tx_ready        <= 1'b0;
                end
            endcase
        end
    end

    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state        <= RX_RST;
            rx_cnt          <= '0;
            rx_analogreset  <= 1'b1;
            rx_digitalreset <= 1'b1;
            rx_ready        <= 1'b0;
        end else if (rx_reset_req || !seq_run) begin
            rx_state        <= RX_RST;
            rx_cnt          <= '0;
            rx_analogreset  <= 1'b1;
            rx_digitalreset <= 1'b1;
            rx_ready        <= 1'b0;
        end else begin
            case (rx_state)
                RX_RST: begin
                    if (rx_cnt == TA_LAST) begin
                        rx_state       <= RX_WAIT;
                        rx_cnt         <= '0;
                        rx_analogreset <= 1'b0;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_WAIT: begin
                    if (rx_ok) begin
                        rx_state <= RX_LTD;
                        rx_cnt   <= '0;
                    end
                end
                RX_LTD: begin
                    // Any dropout restarts the lock qualification from zero.
                    if (!rx_ok) begin
                        rx_state <= RX_WAIT;
                        rx_cnt   <= '0;
                    end else if (rx_cnt == TL_LAST) begin
                        rx_state        <= RX_RDY;
                        rx_digitalreset <= 1'b0;
                        rx_ready        <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_RDY: begin
                    if (!rx_ok) begin
                        rx_state        <= RX_WAIT;
                        rx_cnt          <= '0;
                        rx_digitalreset <= 1'b1;
                        rx_ready        <= 1'b0;
                    end
                end
                default: begin
                    rx_state        <= RX_RST;
                    rx_cnt          <= '0;
                    rx_analogreset  <= 1'b1;
                    rx_digitalreset <= 1'b1;
                    rx_ready        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e10_phy_reset_seq.sv
// tb/tb_e10_phy_reset_seq.sv - self-checking bench for e10_phy_reset_seq
module tb_e10_phy_reset_seq;

    localparam int TA = 4;
    localparam int TD = 8;
    localparam int TL = 10;

    logic clk                = 1'b0;
    logic reset_n            = 1'b0;
    logic tx_reset_req       = 1'b0;
    logic rx_reset_req       = 1'b0;
    logic pll_locked         = 1'b0;
    logic tx_cal_busy        = 1'b0;
    logic rx_cal_busy        = 1'b0;
    logic rx_is_lockedtodata = 1'b0;
    logic tx_analogreset;
    logic tx_digitalreset;
    logic rx_analogreset;
    logic rx_digitalreset;
    logic tx_ready;
    logic rx_ready;

    always #5 clk = ~clk;

    e10_phy_reset_seq #(
        .T_ANALOG (TA),
        .T_DIGITAL(TD),
        .T_LTD    (TL)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .tx_reset_req      (tx_reset_req),
        .rx_reset_req      (rx_reset_req),
        .pll_locked        (pll_locked),
        .tx_cal_busy       (tx_cal_busy),
        .rx_cal_busy       (rx_cal_busy),
        .rx_is_lockedtodata(rx_is_lockedtodata),
        .tx_analogreset    (tx_analogreset),
        .tx_digitalreset   (tx_digitalreset),
        .rx_analogreset    (rx_analogreset),
        .rx_digitalreset   (rx_digitalreset),
        .tx_ready          (tx_ready),
        .rx_ready          (rx_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: edge index n since reset release (first edge = 1),
    // the edge by which each analog hold ends, and the length of the current
    // run of good status (as seen two edges late) after that hold ended.
    int n;
    int tx_a;
    int rx_a;
    int tx_run;
    int rx_run;
    bit tq[$];
    bit rq[$];

    typedef struct {
        int edge_n;
        bit pll;
        bit ltd;
        bit tx_ana;
        bit tx_rdy;
        bit rx_ana;
        bit rx_rdy;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, n);
        end
    endtask

    function automatic void model_reset();
        n      = 0;
        tq.delete();
        rq.delete();
        tx_a   = 1 << 30;
        rx_a   = 1 << 30;
        tx_run = 0;
        rx_run = 0;
    endfunction

    function automatic void model_edge();
        bit ts;
        bit rs;
        if (!reset_n) begin
            model_reset();
            return;
        end
        n++;
        ts = (tq.size() == 2) ? tq[0] : 1'b0;
        rs = (rq.size() == 2) ? rq[0] : 1'b0;
        tq.push_back(pll_locked && !tx_cal_busy);
        rq.push_back(rx_is_lockedtodata && !rx_cal_busy);
        if (tq.size() > 2) void'(tq.pop_front());
        if (rq.size() > 2) void'(rq.pop_front());
        if (tx_reset_req || n == 1) begin
            tx_a   = n + TA;
            tx_run = 0;
        end else if (n > tx_a) begin
            tx_run = ts ? tx_run + 1 : 0;
        end
        if (rx_reset_req || n == 1) begin
            rx_a   = n + TA;
            rx_run = 0;
        end else if (n > rx_a) begin
            rx_run = rs ? rx_run + 1 : 0;
        end
    endfunction

    task automatic check_all();
        bit ta;
        bit tr;
        bit ra;
        bit rr;
        ta = (n == 0) || (n < tx_a);
        ra = (n == 0) || (n < rx_a);
        tr = (tx_run >= TD + 1);
        rr = (rx_run >= TL + 1);
        chk("model_tx_analogreset",  tx_analogreset,  ta);
        chk("model_tx_digitalreset", tx_digitalreset, !tr);
        chk("model_tx_ready",        tx_ready,        tr);
        chk("model_rx_analogreset",  rx_analogreset,  ra);
        chk("model_rx_digitalreset", rx_digitalreset, !rr);
        chk("model_rx_ready",        rx_ready,        rr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic bring_up();
        int guard;
        for (int i = 0; i < 6; i++) begin
            pll_locked         = vt[i].pll;
            rx_is_lockedtodata = vt[i].ltd;
            guard = 0;
            while (n < vt[i].edge_n && guard < 1000) begin
                tick();
                guard++;
            end
            chk($sformatf("bringup_tx_ana_e%0d", vt[i].edge_n), tx_analogreset, vt[i].tx_ana);
            chk($sformatf("bringup_tx_rdy_e%0d", vt[i].edge_n), tx_ready,       vt[i].tx_rdy);
            chk($sformatf("bringup_tx_dig_e%0d", vt[i].edge_n), tx_digitalreset, !vt[i].tx_rdy);
            chk($sformatf("bringup_rx_ana_e%0d", vt[i].edge_n), rx_analogreset, vt[i].rx_ana);
            chk($sformatf("bringup_rx_rdy_e%0d", vt[i].edge_n), rx_ready,       vt[i].rx_rdy);
            chk($sformatf("bringup_rx_dig_e%0d", vt[i].edge_n), rx_digitalreset, !vt[i].rx_rdy);
        end
    endtask

    initial begin
        // Bring-up with steady lock: analog drops on edge 1+TA, TX ready on
        // edge 6+TD, RX ready on edge 6+TL (edge 1 is the first after release).
        vt[0] = '{4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[1] = '{5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        model_reset();
        pll_locked         = 1'b1;
        rx_is_lockedtodata = 1'b1;
        repeat (3) tick();
        chk("reset_tx_analogreset",  tx_analogreset,  1'b1);
        chk("reset_tx_digitalreset", tx_digitalreset, 1'b1);
        chk("reset_rx_analogreset",  rx_analogreset,  1'b1);
        chk("reset_rx_digitalreset", rx_digitalreset, 1'b1);
        chk("reset_tx_ready",        tx_ready,        1'b0);
        chk("reset_rx_ready",        rx_ready,        1'b0);
        reset_n = 1'b1;
        bring_up();

        // CDR glitch: first knock RX back to WAIT, then glitch again at LTD count 7.
        rx_is_lockedtodata = 1'b0;
        tick();
        rx_is_lockedtodata = 1'b1;
        tick();
        tick();
        chk("glitch_rx_drop", rx_ready, 1'b0);
        chk("glitch_tx_hold", tx_ready, 1'b1);
        tick();
        repeat (5) tick();
        rx_is_lockedtodata = 1'b0;
        tick();
        rx_is_lockedtodata = 1'b1;
        tick();
        tick();
        chk("glitch_rx_wait_dig", rx_digitalreset, 1'b1);
        for (int i = 0; i < TL; i++) begin
            tick();
            chk("glitch_rx_not_ready", rx_ready, 1'b0);
            chk("glitch_tx_unaffected", tx_ready, 1'b1);
        end
        tick();
        chk("glitch_rx_ready_after_fresh_lock", rx_ready, 1'b1);

        // PLL loss for three cycles while TX is ready.
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        chk("pll_loss_tx_ready", tx_ready, 1'b0);
        chk("pll_loss_tx_dig",   tx_digitalreset, 1'b1);
        for (int i = 0; i < TD + 2; i++) begin
            tick();
            chk("pll_loss_tx_wait", tx_ready, 1'b0);
            chk("pll_loss_tx_ana",  tx_analogreset, 1'b0);
            chk("pll_loss_rx_hold", rx_ready, 1'b1);
        end
        tick();
        chk("pll_loss_tx_rerelease", tx_ready, 1'b1);

        // Reset request lands on the same edge the CDR loss reaches RX.
        rx_is_lockedtodata = 1'b0;
        tick();
        tick();
        chk("simul_rx_pre", rx_ready, 1'b1);
        rx_reset_req = 1'b1;
        tick();
        chk("simul_rx_ana",   rx_analogreset,  1'b1);
        chk("simul_rx_dig",   rx_digitalreset, 1'b1);
        chk("simul_rx_ready", rx_ready,        1'b0);
        chk("simul_tx_hold",  tx_ready,        1'b1);
        for (int i = 0; i < 2 * TA; i++) begin
            tick();
            chk("req_hold_rx_ana", rx_analogreset, 1'b1);
        end
        rx_reset_req       = 1'b0;
        rx_is_lockedtodata = 1'b1;
        repeat (30) tick();

        // Asynchronous reset while TX is in its digital hold.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_tx_ana",   tx_analogreset,  1'b1);
        chk("async_tx_dig",   tx_digitalreset, 1'b1);
        chk("async_rx_ana",   rx_analogreset,  1'b1);
        chk("async_rx_dig",   rx_digitalreset, 1'b1);
        chk("async_tx_ready", tx_ready,        1'b0);
        chk("async_rx_ready", rx_ready,        1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        bring_up();

        // Randomized status and soft resets against the model.
        for (int i = 0; i < 4000; i++) begin
            pll_locked         = ($urandom_range(0, 99) >= 3);
            rx_is_lockedtodata = ($urandom_range(0, 99) >= 3);
            tx_cal_busy        = ($urandom_range(0, 99) == 0);
            rx_cal_busy        = ($urandom_range(0, 99) == 0);
            tx_reset_req       = ($urandom_range(0, 199) == 0);
            rx_reset_req       = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e10_phy_reset_seq.md
E10_PHY_RESET_SEQ -- requirements
Module: e10_phy_reset_seq

Interface
REQ-001 SHALL have parameter T_ANALOG, default 70, the analog reset hold time in clk cycles (range 1..65535).
REQ-002 SHALL have parameter T_DIGITAL, default 16, the TX digital-reset hold time after PLL lock, in cycles (range 1..65535).
REQ-003 SHALL have parameter T_LTD, default 4000, the continuous rx_is_lockedtodata time required before RX digital release, in cycles (range 1..65535).
REQ-004 SHALL have ports, one per line:
  clk  in  1  single clock; all logic on its rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  tx_reset_req  in  1  synchronous soft reset of the TX path, level or pulse.
  rx_reset_req  in  1  synchronous soft reset of the RX path, level or pulse.
  pll_locked  in  1  TX serial PLL lock; asynchronous.
  tx_cal_busy  in  1  PHY TX calibration busy; asynchronous.
  rx_cal_busy  in  1  PHY RX calibration busy; asynchronous.
  rx_is_lockedtodata  in  1  CDR locked to data; asynchronous.
  tx_analogreset  out  1  to PHY tx_analogreset.
  tx_digitalreset  out  1  to PHY tx_digitalreset.
  rx_analogreset  out  1  to PHY rx_analogreset.
  rx_digitalreset  out  1  to PHY rx_digitalreset.
  tx_ready  out  1  TX path out of reset.
  rx_ready  out  1  RX path out of reset.

Function
REQ-005 SHALL pass each of the four asynchronous status inputs through a 2-flop synchronizer; all latencies below are counted from the synchronized value.
REQ-006 SHALL implement independent TX and RX state machines, each with its own 16-bit counter.
REQ-007 TX states and outputs:
  - TX_RST: tx_analogreset=1, tx_digitalreset=1. Count T_ANALOG cycles, then go to TX_WAIT.
  - TX_WAIT: tx_analogreset=0, tx_digitalreset=1. When pll_locked=1 and tx_cal_busy=0, clear the counter and go to TX_DIG.
  - TX_DIG: tx_analogreset=0, tx_digitalreset=1. Count T_DIGITAL cycles, then go to TX_RDY.
  - TX_RDY: tx_analogreset=0, tx_digitalreset=0, tx_ready=1.
REQ-008 TX: pll_locked=0 or tx_cal_busy=1 while in TX_DIG or TX_RDY SHALL cause a transition to TX_WAIT on the next cycle.
REQ-009 RX states and outputs:
  - RX_RST: rx_analogreset=1, rx_digitalreset=1. Count T_ANALOG cycles, then go to RX_WAIT.
  - RX_WAIT: rx_analogreset=0, rx_digitalreset=1. When rx_cal_busy=0 and rx_is_lockedtodata=1, clear the counter and go to RX_LTD.
  - RX_LTD: rx_analogreset=0, rx_digitalreset=1. Count T_LTD consecutive cycles, then go to RX_RDY.
  - RX_RDY: rx_analogreset=0, rx_digitalreset=0, rx_ready=1.
REQ-010 RX: rx_is_lockedtodata=0 or rx_cal_busy=1 while in RX_LTD or RX_RDY SHALL cause a transition to RX_WAIT; the counter clears and must restart from 0 on the next lock.
REQ-011 Counters SHALL compare against the parameter minus 1, so a state dwells exactly N cycles, and SHALL never wrap.
REQ-012 tx_reset_req=1 SHALL force TX_RST with the counter cleared on the next cycle from any state; rx_reset_req SHALL act the same way on the RX machine.
REQ-013 A reset request in the same cycle as any status transition SHALL win.
REQ-014 While a reset request is held high, the machine SHALL stay in its RST state.
REQ-015 All outputs SHALL be registered; tx_ready and rx_ready SHALL assert in the same cycle the respective digital reset deasserts.
REQ-016 The TX and RX machines SHALL be fully independent: no TX event affects RX and vice versa.

Reset
REQ-017 While reset_n=0:
  - all four PHY reset outputs SHALL be 1;
  - tx_ready and rx_ready SHALL be 0;
  - both FSMs SHALL be in their RST state;
  - counters and synchronizer flops SHALL be 0.
REQ-018 reset_n assertion SHALL take effect asynchronously; deassertion SHALL be synchronized to clk, and sequencing SHALL start on the first clk edge after it.

Structure
REQ-019 The TX and RX state enumerations and the counter width (16) SHALL live in the shared package e10_phy_pkg.
REQ-020 The 2-flop synchronizer SHALL be a sub-module, e10_sync2, instantiated four times; no other sub-modules.

Verification (T_ANALOG=4, T_DIGITAL=8, T_LTD=10)
REQ-021 Bring-up: pll_locked=1 and rx_is_lockedtodata=1 steady, cal_busy=0, release reset_n:
  - analog resets drop 4 cycles after the first edge;
  - tx_ready rises 4+2+8 cycles after that edge (±1 for the WAIT transition);
  - rx_ready rises after 4+2+10 cycles.
REQ-022 CDR glitch: rx_is_lockedtodata drops for 1 cycle at RX_LTD count 7:
  - RX returns to RX_WAIT;
  - rx_ready rises only after 10 fresh locked cycles;
  - TX is unaffected.
REQ-023 Loss in ready: pll_locked=0 for 3 cycles in TX_RDY:
  - tx_digitalreset=1 and tx_ready=0 within 3 cycles of the input edge;
  - re-release occurs 8 cycles after lock returns;
  - tx_analogreset stays 0 throughout.
REQ-024 Simultaneous events: rx_reset_req=1 in the same cycle rx_is_lockedtodata falls in RX_RDY:
  - RX enters RX_RST with both rx resets =1;
  - tx_ready holds at 1.
REQ-025 Mid-sequence reset: reset_n pulsed low during TX_DIG:
  - all resets assert with no clock edge needed;
  - the full sequence restarts from TX_RST/RX_RST.
